// File: rtl/dsa_pkg.sv
// dsa_pkg: shared sizes and FSM state type for decoder_scan_arbiter
package dsa_pkg;
  localparam int NUM_REQ = 8;
  localparam int ADS_W = 3;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE,
    ARB,
`ifdef DSA_GAP_EN
    GRANT,
    GAP
`else
    GRANT
`endif
  } state_t;
endpackage

// File: rtl/decoder_scan_arbiter_if.sv
// decoder_scan_arbiter_if: scheduler inputs (en, req) and 74LS138-style decoder outputs
//   ads/sta/stb/stc: decoder address and enables (G1, G2A_n, G2B_n)
//   sel_n: active-low one-hot select; grant_valid: grant in progress
//   grant_release: pulse on the last grant cycle
interface decoder_scan_arbiter_if;
  import dsa_pkg::*;
  logic en;
  logic [NUM_REQ-1:0] req;
  logic [ADS_W-1:0] ads;
  logic sta;
  logic stb;
  logic stc;
  logic [NUM_REQ-1:0] sel_n;
  logic grant_valid;
  logic grant_release;
  modport master (output en, req, input ads, sta, stb, stc, sel_n, grant_valid, grant_release);
  modport slave (input en, req, output ads, sta, stb, stc, sel_n, grant_valid, grant_release);
endinterface

// File: rtl/dsa_rr_pick.sv
// dsa_rr_pick: combinational round-robin picker, first set req bit from ptr upward mod NUM_REQ
//   req: request lines; ptr: search start; idx: chosen index; found: any request set
module dsa_rr_pick
  import dsa_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ADS_W-1:0]   ptr,
  output logic [ADS_W-1:0]   idx,
  output logic               found
);
  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[ptr + ADS_W'(i)]) idx = ptr + ADS_W'(i);
  end
  assign found = |req;
endmodule

// File: rtl/decoder_scan_arbiter.sv
// decoder_scan_arbiter: round-robin scheduler driving a 3-to-8 decoder, HOLD-cycle grants
//   clk, rst_n (async active-low); bus: decoder_scan_arbiter_if slave modport
//   DSA_GAP_EN: insert one decoder-disabled GAP cycle after each grant (anti-ghosting)
module decoder_scan_arbiter
  import dsa_pkg::*;
#(
  parameter int HOLD = 4
) (
  input logic clk,
  input logic rst_n,
  decoder_scan_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);
`ifdef DSA_GAP_EN
  localparam state_t AFTER = GAP;
`else
  localparam state_t AFTER = ARB;
`endif
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADS_W-1:0] ptr, ptr_n, ads, ads_n, idx;
  logic found, go, gnt_n;
  dsa_rr_pick u_pick (.req(bus.req), .ptr(ptr), .idx(idx), .found(found));
  assign go = bus.en && found;
  assign gnt_n = state_n == GRANT;
  assign bus.ads = ads;
  // GAP re-arbitrates directly so the decoder is dark for exactly one cycle.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ptr_n = ptr;
    ads_n = ads;
    case (state)
      IDLE: state_n = go ? ARB : IDLE;
`ifdef DSA_GAP_EN
      ARB, GAP: begin
`else
      ARB: begin
`endif
        state_n = go ? GRANT : IDLE;
        ads_n = go ? idx : ads;
        cnt_n = go ? '0 : cnt;
      end
      GRANT: begin
        state_n = cnt == LAST ? (bus.en ? AFTER : IDLE) : GRANT;
        ptr_n = cnt == LAST ? ads + ADS_W'(1) : ptr;
        cnt_n = cnt == LAST ? cnt : cnt + CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      ads <= '0;
      bus.sta <= 1'b0;
      bus.stb <= 1'b1;
      bus.stc <= 1'b1;
      bus.sel_n <= '1;
      bus.grant_valid <= 1'b0;
      bus.grant_release <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      ads <= ads_n;
      bus.sta <= gnt_n;
      bus.stb <= !gnt_n;
      bus.stc <= !gnt_n;
      bus.sel_n <= gnt_n ? ~(NUM_REQ'(1) << ads_n) : '1;
      bus.grant_valid <= gnt_n;
      bus.grant_release <= gnt_n && cnt_n == LAST;
    end
  end
endmodule

// File: tb/tb_decoder_scan_arbiter.sv
// tb_decoder_scan_arbiter: scoreboard bench, stimulus queues expected grants, monitor checks them
module tb_decoder_scan_arbiter;
  import dsa_pkg::*;
  localparam int HOLD = 4;
  typedef struct {
    logic [ADS_W-1:0] ads;
    bit b2b;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  decoder_scan_arbiter_if bus ();
  decoder_scan_arbiter #(.HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input bit b);
    exp_t e;
    e.ads = ADS_W'(a);
    e.b2b = b;
    q.push_back(e);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_sel_n", bus.sel_n, 8'hFF);
    chk("rst_enables", {bus.sta, bus.stb, bus.stc}, 3'b011);
    chk("rst_gv_release", {bus.grant_valid, bus.grant_release}, 2'b00);
    chk("rst_ads", bus.ads, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (q.size() != 0) chk({name, "_timeout"}, q.size(), 0);
  endtask

  task automatic settle();
    repeat (HOLD + 4) @(posedge clk);
    #1;
  endtask

  bit in_grant = 1'b0;
  int len = 0;
  int gap = 0;
  logic [ADS_W-1:0] cur_ads = '0;
  logic [NUM_REQ-1:0] exp_sel;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_grant = 1'b0;
      len = 0;
      gap = 0;
      cur_ads = '0;
    end else if (bus.grant_valid === 1'b1) begin
      if (!in_grant) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 0, 1);
        end else begin
          e = q.pop_front();
          exp_sel = ~(NUM_REQ'(1) << e.ads);
          chk("grant_ads", bus.ads, e.ads);
          chk("grant_sel_n", bus.sel_n, exp_sel);
          if (e.b2b) chk("gap_cycles", gap, 1);
        end
        chk("grant_enables", {bus.sta, bus.stb, bus.stc}, 3'b100);
        cur_ads = bus.ads;
        in_grant = 1'b1;
        len = 0;
      end
      len++;
      chk("ads_hold_grant", bus.ads, cur_ads);
      chk("release_timing", bus.grant_release, len == HOLD);
      if (bus.grant_release) in_grant = 1'b0;
      gap = 0;
    end else begin
      if (in_grant) chk("grant_cut_short", len, HOLD);
      in_grant = 1'b0;
      chk("idle_decoder", {bus.sta, bus.stb, bus.stc, bus.sel_n, bus.grant_release}, {3'b011, 8'hFF, 1'b0});
      chk("ads_hold_idle", bus.ads, cur_ads);
      gap++;
    end
  end

  initial begin
    bus.req = '0;
    bus.en = 1'b0;
    #2 do_reset();
    // single requester 0: two-cycle latency, HOLD-long grant
    push(0, 0);
    bus.req = 8'h01;
    bus.en = 1'b1;
    @(posedge clk);
    #1 chk("latency_n1_gv", bus.grant_valid, 0);
    @(posedge clk);
    #1 chk("latency_n2_gv", bus.grant_valid, 1);
    bus.req = '0;
    settle();
    wait_empty("single");
    // all requesting: full rotation with wrap back to 0
    do_reset();
    for (int i = 0; i < 9; i++) push(i % 8, i > 0);
    bus.req = 8'hFF;
    bus.en = 1'b1;
    wait_empty("rotation");
    bus.req = '0;
    settle();
    // ptr moved to 6 by a grant to 5, then 0x41 alternates 6,0,6
    do_reset();
    push(5, 0);
    bus.req = 8'h20;
    bus.en = 1'b1;
    wait_empty("to_ptr6");
    bus.req = 8'h41;
    push(6, 1);
    push(0, 1);
    push(6, 1);
    wait_empty("wrap");
    bus.req = '0;
    settle();
    // dropping req and en mid-grant does not shorten it, then idle
    do_reset();
    push(3, 0);
    bus.req = 8'h08;
    bus.en = 1'b1;
    wait_empty("nonpreempt");
    bus.req = '0;
    bus.en = 1'b0;
    settle();
    chk("after_drop_sel_n", bus.sel_n, 8'hFF);
    // asynchronous reset between clock edges mid-grant
    do_reset();
    push(2, 0);
    bus.req = 8'h04;
    bus.en = 1'b1;
    wait_empty("async");
    chk("pre_reset_gv", bus.grant_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel_n", bus.sel_n, 8'hFF);
    chk("async_stb", bus.stb, 1);
    chk("async_gv", bus.grant_valid, 0);
    do_reset();
    settle();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/decoder_scan_arbiter.md
DECODER_SCAN_ARBITER -- requirements
Module: decoder_scan_arbiter

Interface
REQ-001 Parameter HOLD, default 4, grant length in clk cycles; legal range 1..256.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  scheduler enable; sampled each cycle.
REQ-005 req  input  8  request lines, bit i = requester i, active-high, level.
REQ-006 ads  output  3  decoder address = index of granted requester.
REQ-007 sta  output  1  decoder enable G1, active-high.
REQ-008 stb  output  1  decoder enable G2A, active-low.
REQ-009 stc  output  1  decoder enable G2B, active-low.
REQ-010 sel_n  output  8  active-low one-hot select, 74LS138 output convention.
REQ-011 grant_valid  output  1  high while a grant is being driven.
REQ-012 release  output  1  one-cycle pulse on the last cycle of each grant.

Function
REQ-013 FSM states IDLE, ARB, GRANT, GAP; all outputs registered.
REQ-014 IDLE: en=1 and req!=0 -> ARB; otherwise stay in IDLE.
REQ-015 ARB: select first set req bit searching ptr, ptr+1, ... mod 8; load ads; -> GRANT.
REQ-016 ARB with req==0 or en=0 -> IDLE, ads unchanged.
REQ-017 GRANT: sta=1, stb=0, stc=0, sel_n=~(8'b1<<ads), grant_valid=1.
REQ-018 Outside GRANT: sta=0, stb=1, stc=1, sel_n=8'hFF, grant_valid=0.
REQ-019 Grant lasts exactly HOLD cycles; counter 8-bit, clears on GRANT entry.
REQ-020 Last GRANT cycle: release=1; ptr <= (ads+1) mod 8, wrapping 7->0.
REQ-021 Grant is non-preemptive: req[ads] dropping or en dropping mid-grant does not shorten it.
REQ-022 After GRANT: -> GAP if gap compiled in, else -> ARB; en=0 at exit -> IDLE.
REQ-023 Latency: req rising in IDLE at cycle n -> grant_valid=1 at cycle n+2.
REQ-024 Simultaneous requests resolved strictly round-robin; no requester waits more than 7 grants.
REQ-025 ads holds its last value while not granting.

Reset
REQ-026 Reset state: IDLE, ptr=0, counter=0, ads=0, sta=0, stb=1, stc=1, sel_n=8'hFF, grant_valid=0, release=0.
REQ-027 Reset asserted mid-grant forces reset state immediately, without waiting for clk.
REQ-028 First grant after reset favours requester 0.

Configuration
REQ-029 Macro DSA_GAP_EN defined: one GAP cycle, decoder disabled, between consecutive grants (anti-ghosting).
REQ-030 DSA_GAP_EN undefined: GAP state absent; GRANT -> ARB directly, one ARB cycle with decoder disabled.

Structure
REQ-031 Package dsa_pkg holds state enum, NUM_REQ=8, ADS_W=3, CNT_W=8.
REQ-032 Sub-module dsa_rr_pick: combinational round-robin picker (req, ptr -> idx, found).
REQ-033 No other sub-modules; decoder function implemented inline for sel_n.

Verification
REQ-034 Reset then req=8'h01, en=1, HOLD=4 -> cycle 2 ads=0, sel_n=8'hFE, grant_valid=1 for 4 cycles, release on 4th.
REQ-035 req=8'hFF held -> grant order ads 0,1,2,...,7,0; sel_n FE,FD,FB,...,7F.
REQ-036 ptr=6, req=8'h41 -> grant 6, then 0 (wrap), then 6.
REQ-037 req[3] dropped and en=0 mid-grant -> grant completes HOLD cycles, then IDLE, sel_n=8'hFF.
REQ-038 DSA_GAP_EN defined, req=8'h03 -> exactly one cycle sta=0, sel_n=8'hFF between grants 0 and 1.
REQ-039 rst_n low mid-grant between clock edges -> sel_n=8'hFF, stb=1, grant_valid=0 immediately.
